ahb_master_arbiter: RTL and testbench



---
 rtl/ahb_arb_pkg.sv | 16 +
 rtl/ahb_master_arbiter_if.sv | 28 ++
 rtl/ahb_rr_arbiter.sv | 39 +++
 rtl/ahb_master_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_ahb_master_arbiter.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ahb_arb_pkg.sv
// Shared types and AHB-lite encodings for the AHB master arbiter.
package ahb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } ahb_arb_state_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HSIZE_BYTE    = 3'b000;
  localparam logic [1:0] HRESP_OKAY    = 2'b00;

endpackage

// File: rtl/ahb_master_arbiter_if.sv
// AHB-lite master port signal bundle; master drives the address/data phase, slave responds.
interface ahb_master_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 16
) ();

  logic [ADDR_W-1:0] haddr;
  logic [DATA_W-1:0] hwdata;
  logic [1:0]        htrans;
  logic [2:0]        hburst;
  logic [2:0]        hsize;
  logic              hwrite;
  logic              hsel;
  logic              hready;
  logic [DATA_W-1:0] hrdata;
  logic [1:0]        hresp;

  modport master (
    output haddr, hwdata, htrans, hburst, hsize, hwrite, hsel,
    input  hready, hrdata, hresp
  );

  modport slave (
    input  haddr, hwdata, htrans, hburst, hsize, hwrite, hsel,
    output hready, hrdata, hresp
  );

endinterface

// File: rtl/ahb_rr_arbiter.sv
// Round-robin pick: first set request searching upward from ptr_q+1, wrapping.
module ahb_rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IdxW    = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               grant_en_i,
  output logic               any_o,
  output logic [IdxW-1:0]    win_o
);

  logic [IdxW-1:0] ptr_q;
  logic [IdxW-1:0] cand;

  always_comb begin
    any_o = 1'b0;
    win_o = '0;
    cand  = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = IdxW'((32'(ptr_q) + k) % NUM_REQ);
      if (!any_o && req_i[cand]) begin
        any_o = 1'b1;
        win_o = cand;
      end
    end
  end

  // Reset to the last slot so requester 0 has top priority first.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= IdxW'(NUM_REQ - 1);
    end else if (grant_en_i) begin
      ptr_q <= win_o;
    end
  end

endmodule

// File: rtl/ahb_master_arbiter.sv
// Shares one AHB-lite master port among NUM_REQ requesters, single non-pipelined transfers.
// Define AHB_ARB_TIMEOUT_EN to abort transfers stalled for TIMEOUT_CYCLES wait states.
module ahb_master_arbiter
  import ahb_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 16,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                  hclk,
  input  logic                  hreset,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ-1:0]    req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]    gnt,
  output logic [NUM_REQ-1:0]    done,
  output logic                  err,
  output logic [DATA_W-1:0]     rdata,
  ahb_master_arbiter_if.master  ahb
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_num_req_check
    $error("NUM_REQ must be in 2..8");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_timeout_check
    $error("TIMEOUT_CYCLES must be nonzero");
  end

  ahb_arb_state_t    state_q, state_d;
  logic [IdxW-1:0]   owner_q, owner_d;
  logic [ADDR_W-1:0] haddr_q, haddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] hwdata_q, hwdata_d;
  logic [1:0]        htrans_q, htrans_d;
  logic              hwrite_q, hwrite_d;
  logic              hsel_q, hsel_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic              any_req;
  logic [IdxW-1:0]   win;
  logic              grant_en;

  ahb_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IdxW    (IdxW)
  ) u_rr (
    .clk_i      (hclk),
    .rst_i      (hreset),
    .req_i      (req),
    .grant_en_i (grant_en),
    .any_o      (any_req),
    .win_o      (win)
  );

`ifdef AHB_ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            stall;
  logic            timeout;

  assign stall   = (state_q != IDLE) && !ahb.hready;
  assign timeout = stall && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));
  // Any state change (normal progress or timeout) restarts the count.
  assign cnt_d   = (stall && !timeout) ? cnt_q + 1'b1 : '0;
`endif

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    haddr_d  = haddr_q;
    wdata_d  = wdata_q;
    hwdata_d = hwdata_q;
    htrans_d = htrans_q;
    hwrite_d = hwrite_q;
    hsel_d   = hsel_q;
    gnt_d    = '0;
    done_d   = '0;
    err_d    = err_q;
    rdata_d  = rdata_q;
    grant_en = 1'b0;

    unique case (state_q)
      IDLE: begin
        // The cycle carrying done is the mandatory bus-idle gap.
        if (any_req && !(|done_q)) begin
          grant_en     = 1'b1;
          owner_d      = win;
          haddr_d      = req_addr[win*ADDR_W +: ADDR_W];
          wdata_d      = req_wdata[win*DATA_W +: DATA_W];
          hwrite_d     = req_write[win];
          htrans_d     = HTRANS_NONSEQ;
          hsel_d       = 1'b1;
          gnt_d[win]   = 1'b1;
          state_d      = ADDR;
        end
      end
      ADDR: begin
        if (ahb.hready) begin
          htrans_d = HTRANS_IDLE;
          hsel_d   = 1'b0;
          if (hwrite_q) hwdata_d = wdata_q;
          state_d  = DATA;
        end
      end
      DATA: begin
        if (ahb.hready) begin
          if (!hwrite_q) rdata_d = ahb.hrdata;
          err_d           = (ahb.hresp != HRESP_OKAY);
          done_d[owner_q] = 1'b1;
          state_d         = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef AHB_ARB_TIMEOUT_EN
    if (timeout) begin
      done_d[owner_q] = 1'b1;
      err_d           = 1'b1;
      htrans_d        = HTRANS_IDLE;
      hsel_d          = 1'b0;
      state_d         = IDLE;
    end
`endif
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      haddr_q  <= '0;
      wdata_q  <= '0;
      hwdata_q <= '0;
      htrans_q <= HTRANS_IDLE;
      hwrite_q <= 1'b0;
      hsel_q   <= 1'b0;
      gnt_q    <= '0;
      done_q   <= '0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
`ifdef AHB_ARB_TIMEOUT_EN
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      haddr_q  <= haddr_d;
      wdata_q  <= wdata_d;
      hwdata_q <= hwdata_d;
      htrans_q <= htrans_d;
      hwrite_q <= hwrite_d;
      hsel_q   <= hsel_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
`ifdef AHB_ARB_TIMEOUT_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

  assign ahb.haddr  = haddr_q;
  assign ahb.hwdata = hwdata_q;
  assign ahb.htrans = htrans_q;
  assign ahb.hburst = HBURST_SINGLE;
  assign ahb.hsize  = HSIZE_BYTE;
  assign ahb.hwrite = hwrite_q;
  assign ahb.hsel   = hsel_q;
  assign gnt        = gnt_q;
  assign done       = done_q;
  assign err        = err_q;
  assign rdata      = rdata_q;

endmodule

// File: tb/tb_ahb_master_arbiter.sv
// Bench for ahb_master_arbiter: directed cases plus random traffic against a transaction model.
module tb_ahb_master_arbiter;
  import ahb_arb_pkg::*;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 16;
  localparam int TO = 16;

  logic              hclk = 1'b0;
  logic              hreset;
  logic [N-1:0]      req, req_write, gnt, done;
  logic [N*AW-1:0]   req_addr;
  logic [N*DW-1:0]   req_wdata;
  logic              err;
  logic [DW-1:0]     rdata;

  ahb_master_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  ahb_master_arbiter #(
    .NUM_REQ        (N),
    .ADDR_W         (AW),
    .DATA_W         (DW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .hclk      (hclk),
    .hreset    (hreset),
    .req       (req),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .gnt       (gnt),
    .done      (done),
    .err       (err),
    .rdata     (rdata),
    .ahb       (bus.master)
  );

  always #5 hclk = ~hclk;

  int checks = 0;
  int errors = 0;

  // Model state: pending requests, their payloads, last granted slot, expected rdata.
  logic [N-1:0]  pend;
  logic [AW-1:0] a_addr [N];
  logic [DW-1:0] a_wd   [N];
  logic          a_wr   [N];
  int            model_last;
  logic [DW-1:0] rdata_m;

  task automatic step();
    @(posedge hclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    req = pend;
    for (int i = 0; i < N; i++) begin
      req_write[i]            = a_wr[i];
      req_addr[i*AW +: AW]    = a_addr[i];
      req_wdata[i*DW +: DW]   = a_wd[i];
    end
  endtask

  task automatic issue(input int i, input logic wr, input logic [AW-1:0] ad,
                       input logic [DW-1:0] wd);
    a_wr[i]   = wr;
    a_addr[i] = ad;
    a_wd[i]   = wd;
    pend[i]   = 1'b1;
    drive();
  endtask

  // Round-robin rule: first pending requester after the last winner, wrapping.
  function automatic int pick();
    for (int k = 1; k <= N; k++) begin
      if (pend[(model_last + k) % N]) return (model_last + k) % N;
    end
    return 0;
  endfunction

  task automatic expect_reset(input string tag);
    chk({tag, "_haddr"}, bus.haddr, '0);
    chk({tag, "_hwdata"}, bus.hwdata, '0);
    chk({tag, "_ctrl"}, {bus.htrans, bus.hburst, bus.hsize, bus.hwrite, bus.hsel}, '0);
    chk({tag, "_gnt_done"}, {gnt, done}, '0);
    chk({tag, "_err"}, err, 1'b0);
    chk({tag, "_rdata"}, rdata, '0);
  endtask

  task automatic xfer(input int aw, input int dw, input logic [1:0] resp,
                      input logic [DW-1:0] rd);
    int            w;
    logic          wr;
    logic [AW-1:0] ad;
    logic [DW-1:0] wd;
    w  = pick();
    wr = a_wr[w];
    ad = a_addr[w];
    wd = a_wd[w];
    bus.hready = 1'b1;
    step();
    chk("gnt", gnt, 64'(1 << w));
    chk("addr_phase", {bus.htrans, bus.hsel, bus.hburst, bus.hsize}, {HTRANS_NONSEQ, 1'b1, 6'b0});
    chk("haddr", bus.haddr, ad);
    chk("hwrite", bus.hwrite, wr);
    model_last = w;
    pend[w]    = 1'b0;
    drive();
    for (int k = 0; k < aw; k++) begin
      bus.hready = 1'b0;
      step();
      chk("addr_wait", {gnt, done, bus.htrans, bus.hsel}, {8'b0, HTRANS_NONSEQ, 1'b1});
    end
    bus.hready = 1'b1;
    step();
    chk("data_phase", {bus.htrans, bus.hsel, done}, '0);
    chk("haddr_held", bus.haddr, ad);
    if (wr) chk("hwdata", bus.hwdata, wd);
    for (int k = 0; k < dw; k++) begin
      bus.hready = 1'b0;
      step();
      chk("data_wait", done, '0);
    end
    bus.hready = 1'b1;
    bus.hrdata = rd;
    bus.hresp  = resp;
    step();
    if (!wr) rdata_m = rd;
    chk("done", done, 64'(1 << w));
    chk("err", err, resp != HRESP_OKAY);
    chk("rdata", rdata, rdata_m);
    bus.hresp  = HRESP_OKAY;
    bus.hrdata = DW'($urandom);
    step();
    chk("idle_gap", {gnt, done, bus.htrans, bus.hsel}, '0);
  endtask

  initial begin
    int           w;
    logic [N-1:0] m;
    logic [1:0]   rsp;

    pend       = '0;
    for (int i = 0; i < N; i++) begin
      a_addr[i] = '0;
      a_wd[i]   = '0;
      a_wr[i]   = 1'b0;
    end
    drive();
    hreset     = 1'b1;
    bus.hready = 1'b1;
    bus.hrdata = '0;
    bus.hresp  = HRESP_OKAY;
    step();
    step();
    expect_reset("reset");
    hreset     = 1'b0;
    model_last = N - 1;
    rdata_m    = '0;

    // Directed: single write, read with data wait states, error response.
    issue(2, 1'b1, 32'h0000_1000, 16'hBEEF);
    xfer(0, 0, HRESP_OKAY, 16'h5555);
    issue(0, 1'b0, 32'h0000_0020, 16'h0);
    xfer(0, 2, HRESP_OKAY, 16'h1234);
    issue(1, 1'b1, 32'h0000_0444, 16'hA5A5);
    xfer(1, 0, 2'b01, 16'h0);

    // Fairness from reset with all requests held high.
    hreset = 1'b1;
    step();
    hreset = 1'b0;
    for (int i = 0; i < N; i++) issue(i, 1'(i % 2), AW'($urandom), DW'($urandom));
    for (int c = 1; c <= 20; c++) begin
      step();
      chk("fair_gnt", gnt, (c % 4 == 1) ? 64'(1 << ((c / 4) % 4)) : 64'(0));
      chk("fair_done", done, (c % 4 == 3) ? 64'(1 << ((c / 4) % 4)) : 64'(0));
    end
    pend = '0;
    drive();

    // Reset during a stalled data phase: no done, then requester 3 alone.
    model_last = 0;
    issue(2, 1'b0, 32'h0000_0300, 16'h0);
    step();
    chk("rst_pre_gnt", gnt, 64'(1 << 2));
    pend = '0;
    drive();
    step();
    bus.hready = 1'b0;
    step();
    hreset = 1'b1;
    step();
    expect_reset("rst_data");
    hreset     = 1'b0;
    bus.hready = 1'b1;
    model_last = N - 1;
    rdata_m    = '0;
    step();
    chk("rst_no_done", {done, gnt}, '0);
    issue(3, 1'b0, 32'h0000_0380, 16'h0);
    xfer(0, 0, HRESP_OKAY, 16'h3C3C);

    // Address-phase stall beyond the timeout threshold.
    issue(1, 1'b0, 32'h0000_0900, 16'h0);
    w = pick();
    step();
    chk("stall_gnt", gnt, 64'(1 << w));
    model_last = w;
    pend       = '0;
    drive();
    bus.hready = 1'b0;
    for (int k = 1; k < TO; k++) begin
      step();
      chk("stall_hold", {done, bus.htrans, bus.hsel}, {4'b0, HTRANS_NONSEQ, 1'b1});
    end
`ifdef AHB_ARB_TIMEOUT_EN
    step();
    chk("timeout_done", done, 64'(1 << w));
    chk("timeout_err", err, 1'b1);
    chk("timeout_bus", {bus.htrans, bus.hsel}, '0);
    chk("timeout_rdata", rdata, rdata_m);
    bus.hready = 1'b1;
    step();
    chk("timeout_idle", {gnt, done, bus.htrans}, '0);
`else
    for (int k = 0; k < 4; k++) begin
      step();
      chk("no_timeout_hold", {done, bus.htrans, bus.hsel}, {4'b0, HTRANS_NONSEQ, 1'b1});
    end
    bus.hready = 1'b1;
    step();
    bus.hrdata = 16'h0F0F;
    step();
    rdata_m = 16'h0F0F;
    chk("stall_done", done, 64'(1 << w));
    chk("stall_rdata", rdata, rdata_m);
    step();
`endif

    // Random traffic against the transaction model.
    for (int it = 0; it < 24; it++) begin
      m = N'($urandom_range(1, (1 << N) - 1));
      for (int i = 0; i < N; i++) begin
        if (m[i] && !pend[i]) issue(i, 1'($urandom), AW'($urandom), DW'($urandom));
      end
      rsp = ($urandom_range(0, 3) == 0) ? 2'b01 : HRESP_OKAY;
      xfer($urandom_range(0, 2), $urandom_range(0, 3), rsp, DW'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
